// File: rtl/cam_line_capture_pkg.sv
// Shared definitions for the camera line capture block: command codes and FSM states.
package cam_line_capture_pkg;

   typedef enum logic [1:0] {
      CMD_NONE        = 2'd0,
      CMD_FRAME_START = 2'd1,
      CMD_ROW         = 2'd2,
      CMD_FRAME_END   = 2'd3
   } cmd_t;

   typedef enum logic [2:0] {
      IDLE,
      WRITE_FRAME_START,
      CHECK_ROW_COUNT,
      PREPARE_ROW_START,
      PREPARE_ROW,
      WRITE_ROW_START,
      WRITE_FRAME_END,
      FRAME_DONE
   } cap_state_t;

endpackage

// File: rtl/CDC_Word_Synchronizer.sv
// Toggle-handshake word crossing with a single-entry output register on the receive side.
// Handshake: a word moves when valid and ready are both high on the same rising edge;
// the receive side holds pop_valid and pop_data steady until pop_ready accepts them.
module CDC_Word_Synchronizer #(
   parameter int WIDTH = 2
) (
   input  logic             clk_src,
   input  logic             rst_src_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             push_ready,
   input  logic             clk_dst,
   input  logic             rst_dst_n,
   input  logic             pop_ready,
   output logic             pop_valid,
   output logic [WIDTH-1:0] pop_data
);
   logic             req_tgl;
   logic [WIDTH-1:0] data_hold;
   logic [1:0]       ack_sync;
   logic [1:0]       req_sync;
   logic             ack_tgl;
   logic             load;

   // data_hold only changes while no request is outstanding, so the receiver may sample it directly.
   always_ff @(posedge clk_src or negedge rst_src_n) begin
      if (!rst_src_n) begin
         req_tgl   <= 1'b0;
         data_hold <= '0;
         ack_sync  <= 2'b00;
      end else begin
         ack_sync <= {ack_sync[0], ack_tgl};
         if (push && push_ready) begin
            req_tgl   <= ~req_tgl;
            data_hold <= push_data;
         end
      end
   end

   assign push_ready = (req_tgl == ack_sync[1]);
   assign load       = (req_sync[1] != ack_tgl) && (!pop_valid || pop_ready);

   always_ff @(posedge clk_dst or negedge rst_dst_n) begin
      if (!rst_dst_n) begin
         req_sync  <= 2'b00;
         ack_tgl   <= 1'b0;
         pop_valid <= 1'b0;
         pop_data  <= '0;
      end else begin
         req_sync <= {req_sync[0], req_tgl};
         if (load) begin
            pop_data  <= data_hold;
            pop_valid <= 1'b1;
            ack_tgl   <= ~ack_tgl;
         end else if (pop_ready) begin
            pop_valid <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/Reset_Synchronizer.sv
// Asynchronous-assert, synchronous-deassert reset for one clock domain (3 flops).
module Reset_Synchronizer (
   input  logic clk,
   input  logic arst_n,
   output logic rst_n
);
   logic [2:0] sync;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) sync <= 3'b000;
      else         sync <= {sync[1:0], 1'b1};
   end

   assign rst_n = sync[2];
endmodule

// File: rtl/sdpb_1kx32.sv
// 1K x 32 simple dual-port RAM: write port on clk_w, registered read port on clk_r.
module sdpb_1kx32 (
   input  logic        clk_w,
   input  logic        we,
   input  logic [9:0]  waddr,
   input  logic [31:0] wdata,
   input  logic        clk_r,
   input  logic        rst_r_n,
   input  logic        re,
   input  logic [9:0]  raddr,
   output logic [31:0] rdata
);
   logic [31:0] mem [1024];

   always_ff @(posedge clk_w) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk_r or negedge rst_r_n) begin
      if (!rst_r_n)  rdata <= '0;
      else if (re)   rdata <= mem[raddr];
   end
endmodule

// File: rtl/cam_line_capture.sv
// Captures RGB565 camera rows into ping-pong line buffers and reports
// frame start / row ready / frame end to the memory controller across clock domains.
module cam_line_capture
   import cam_line_capture_pkg::*;
#(
   parameter int FRAME_WIDTH  = 640,
   parameter int FRAME_HEIGHT = 480
) (
   input  logic        clk_cam,
   input  logic        reset_n,
   input  logic        clk_mem,
   input  logic        init,
   input  logic        mem_controller_rdy,
   input  logic [9:0]  mem_addr,
   input  logic        v_sync,
   input  logic        h_ref,
   input  logic [7:0]  cam_data,
   output logic [31:0] pixel_data,
   output logic [1:0]  command_data,
   output logic        command_data_valid
);
   localparam int COL_W = $clog2(FRAME_WIDTH + 1);
   localparam int ROW_W = $clog2(FRAME_HEIGHT + 1);

   logic             rst_cam_n, rst_mem_n;
   cap_state_t       state, state_next;
   logic [COL_W-1:0] col;
   logic [1:0]       phase;
   logic [7:0]       word_hi;
   logic [15:0]      word_lo;
   logic [ROW_W-1:0] row_count;
   logic             wr_en, write_buf_id, read_buf_id, have_row;
   logic             cmd_push, cmd_ready;
   cmd_t             cmd_code;
   logic             row_full, wr_word;
   logic [1:0]       read_buf_m, have_row_m;
   logic             sel_q;
   logic [31:0]      q_a, q_b, wdata;
   logic [9:0]       waddr;

   Reset_Synchronizer u_rst_cam (.clk(clk_cam), .arst_n(reset_n), .rst_n(rst_cam_n));
   Reset_Synchronizer u_rst_mem (.clk(clk_mem), .arst_n(reset_n), .rst_n(rst_mem_n));

   always_ff @(posedge clk_cam or negedge rst_cam_n) begin
      if (!rst_cam_n) state <= IDLE;
      else            state <= state_next;
   end

   assign row_full = (col == COL_W'(FRAME_WIDTH));

   always_comb begin
      state_next = state;
      cmd_push   = 1'b0;
      cmd_code   = CMD_NONE;
      case (state)
         IDLE:              if (init && v_sync) state_next = WRITE_FRAME_START;
         WRITE_FRAME_START: if (cmd_ready && !v_sync) begin
                               cmd_push   = 1'b1;
                               cmd_code   = CMD_FRAME_START;
                               state_next = CHECK_ROW_COUNT;
                            end
         CHECK_ROW_COUNT:   state_next = (row_count == ROW_W'(FRAME_HEIGHT)) ? WRITE_FRAME_END
                                                                             : PREPARE_ROW_START;
         PREPARE_ROW_START: state_next = PREPARE_ROW;
         PREPARE_ROW:       if (row_full) state_next = WRITE_ROW_START;
         WRITE_ROW_START:   if (cmd_ready) begin
                               cmd_push   = 1'b1;
                               cmd_code   = CMD_ROW;
                               state_next = CHECK_ROW_COUNT;
                            end
         WRITE_FRAME_END:   if (cmd_ready) begin
                               cmd_push   = 1'b1;
                               cmd_code   = CMD_FRAME_END;
                               state_next = FRAME_DONE;
                            end
         FRAME_DONE:        if (v_sync) state_next = WRITE_FRAME_START;
         default:           state_next = IDLE;
      endcase
   end

   // Byte order within a pixel pair: [15:8], [7:0], [31:24], then [23:16] lands with the write.
   always_ff @(posedge clk_cam or negedge rst_cam_n) begin
      if (!rst_cam_n) begin
         col          <= '0;
         phase        <= 2'd0;
         word_hi      <= '0;
         word_lo      <= '0;
         row_count    <= '0;
         wr_en        <= 1'b0;
         write_buf_id <= 1'b0;
         read_buf_id  <= 1'b0;
         have_row     <= 1'b0;
      end else begin
         if (state == WRITE_FRAME_START && cmd_push) row_count <= '0;
         if (state == WRITE_ROW_START && cmd_push)   row_count <= row_count + ROW_W'(1);
         if (state == PREPARE_ROW_START) begin
            col   <= '0;
            phase <= 2'd0;
            wr_en <= 1'b1;
         end
         if (state == PREPARE_ROW) begin
            if (row_full) begin
               wr_en        <= 1'b0;
               read_buf_id  <= write_buf_id;
               have_row     <= 1'b1;
               write_buf_id <= ~write_buf_id;
            end else if (h_ref) begin
               phase <= phase + 2'd1;
               case (phase)
                  2'd0:    word_lo[15:8] <= cam_data;
                  2'd1:    begin word_lo[7:0] <= cam_data; col <= col + COL_W'(1); end
                  2'd2:    word_hi <= cam_data;
                  default: col <= col + COL_W'(1);
               endcase
            end
         end
      end
   end

   assign wr_word = wr_en && (state == PREPARE_ROW) && h_ref && !row_full && (phase == 2'd3);
   assign wdata   = {word_hi, cam_data, word_lo};
   assign waddr   = 10'(col >> 1);

   sdpb_1kx32 u_buf_a (
      .clk_w(clk_cam), .we(wr_word && !write_buf_id), .waddr(waddr), .wdata(wdata),
      .clk_r(clk_mem), .rst_r_n(rst_mem_n), .re(have_row_m[1] && !read_buf_m[1]),
      .raddr(mem_addr), .rdata(q_a)
   );

   sdpb_1kx32 u_buf_b (
      .clk_w(clk_cam), .we(wr_word && write_buf_id), .waddr(waddr), .wdata(wdata),
      .clk_r(clk_mem), .rst_r_n(rst_mem_n), .re(have_row_m[1] && read_buf_m[1]),
      .raddr(mem_addr), .rdata(q_b)
   );

   // Buffer selection is quasi-static: it settles before the row-ready command crosses.
   always_ff @(posedge clk_mem or negedge rst_mem_n) begin
      if (!rst_mem_n) begin
         read_buf_m <= 2'b00;
         have_row_m <= 2'b00;
         sel_q      <= 1'b0;
      end else begin
         read_buf_m <= {read_buf_m[0], read_buf_id};
         have_row_m <= {have_row_m[0], have_row};
         sel_q      <= read_buf_m[1];
      end
   end

   assign pixel_data = sel_q ? q_b : q_a;

   CDC_Word_Synchronizer #(.WIDTH(2)) u_cmd_sync (
      .clk_src(clk_cam), .rst_src_n(rst_cam_n), .push(cmd_push), .push_data(cmd_code),
      .push_ready(cmd_ready),
      .clk_dst(clk_mem), .rst_dst_n(rst_mem_n), .pop_ready(mem_controller_rdy),
      .pop_valid(command_data_valid), .pop_data(command_data)
   );
endmodule

// File: tb/tb_cam_line_capture.sv
// Directed bench for cam_line_capture with an 8-pixel, 4-row frame.
module tb_cam_line_capture;
   localparam int W = 8;
   localparam int H = 4;

   logic        clk_cam = 1'b0;
   logic        clk_mem = 1'b0;
   logic        reset_n = 1'b0;
   logic        init = 1'b0;
   logic        mem_controller_rdy = 1'b1;
   logic [9:0]  mem_addr = '0;
   logic        v_sync = 1'b0;
   logic        h_ref = 1'b0;
   logic [7:0]  cam_data = '0;
   logic [31:0] pixel_data;
   logic [1:0]  command_data;
   logic        command_data_valid;

   int checks = 0;
   int failures = 0;
   logic [1:0] got_q[$];
   logic [1:0] exp_q[$];

   typedef struct {
      logic [7:0]  base;
      logic [7:0]  step;
      logic [31:0] w0;
      logic [31:0] w3;
   } row_vec_t;
   row_vec_t rows[H];

   cam_line_capture #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H)) dut (
      .clk_cam(clk_cam), .reset_n(reset_n), .clk_mem(clk_mem), .init(init),
      .mem_controller_rdy(mem_controller_rdy), .mem_addr(mem_addr), .v_sync(v_sync),
      .h_ref(h_ref), .cam_data(cam_data), .pixel_data(pixel_data),
      .command_data(command_data), .command_data_valid(command_data_valid)
   );

   // clock / reset
   always #5 clk_cam = ~clk_cam;
   always #7 clk_mem = ~clk_mem;

   // accepted commands, in order
   always @(posedge clk_mem) begin
      if (command_data_valid && mem_controller_rdy) got_q.push_back(command_data);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_cmd(input logic [1:0] exp, input string name);
      logic [1:0] e;
      exp_q.push_back(exp);
      for (int i = 0; i < 300 && got_q.size() == 0; i++) @(negedge clk_mem);
      e = exp_q.pop_front();
      if (got_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s: no command within bound, expected %0d", name, e);
      end else begin
         check(name, 32'(got_q.pop_front()), 32'(e));
      end
   endtask

   // driver tasks
   task automatic send_row(input logic [7:0] base, input logic [7:0] step, input bit gap, input bit extra);
      for (int i = 0; i < 2 * W; i++) begin
         @(negedge clk_cam);
         h_ref    = 1'b1;
         cam_data = 8'(base + 8'(i) * step);
         if (gap && i == 5) begin
            @(negedge clk_cam);
            h_ref    = 1'b0;
            cam_data = 8'hEE;
         end
      end
      if (extra) begin
         repeat (2) begin
            @(negedge clk_cam);
            h_ref    = 1'b1;
            cam_data = 8'h55;
         end
      end
      @(negedge clk_cam);
      h_ref = 1'b0;
   endtask

   task automatic read_word(input logic [9:0] addr, input logic [31:0] exp, input string name);
      @(negedge clk_mem);
      mem_addr = addr;
      @(negedge clk_mem);
      check(name, pixel_data, exp);
   endtask

   task automatic pulse_vsync();
      v_sync = 1'b1;
      repeat (5) @(negedge clk_cam);
      v_sync = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rows[0] = '{8'h11, 8'h11, 32'h3344_1122, 32'hFF10_DDEE};
      rows[1] = '{8'h00, 8'h01, 32'h0203_0001, 32'h0E0F_0C0D};
      rows[2] = '{8'hF0, 8'h01, 32'hF2F3_F0F1, 32'hFEFF_FCFD};
      rows[3] = '{8'h80, 8'h02, 32'h8486_8082, 32'h9C9E_989A};

      repeat (3) @(negedge clk_cam);
      check("reset_valid", 32'(command_data_valid), 32'd0);
      check("reset_cmd", 32'(command_data), 32'd0);
      check("reset_pixel", pixel_data, 32'd0);
      reset_n = 1'b1;
      repeat (6) @(negedge clk_cam);

      init   = 1'b1;
      v_sync = 1'b1;
      repeat (20) @(negedge clk_cam);
      check("no_cmd_in_vsync", 32'(command_data_valid), 32'd0);
      v_sync = 1'b0;
      expect_cmd(2'd1, "frame_start");

      for (int r = 0; r < H; r++) begin
         if (r == 2) mem_controller_rdy = 1'b0;
         send_row(rows[r].base, rows[r].step, r == 1, r == 0);
         if (r == 2) begin
            repeat (50) @(negedge clk_mem);
            check("held_valid", 32'(command_data_valid), 32'd1);
            check("held_data", 32'(command_data), 32'd2);
            check("held_not_taken", 32'(got_q.size()), 32'd0);
            mem_controller_rdy = 1'b1;
         end
         expect_cmd(2'd2, $sformatf("row%0d_ready", r));
         read_word(10'd0, rows[r].w0, $sformatf("row%0d_word0", r));
         read_word(10'(W / 2 - 1), rows[r].w3, $sformatf("row%0d_wordlast", r));
      end

      expect_cmd(2'd3, "frame_end");
      repeat (30) @(negedge clk_mem);
      check("no_duplicate", 32'(got_q.size()), 32'd0);

      init = 1'b0;
      pulse_vsync();
      expect_cmd(2'd1, "restart_frame_start");

      for (int i = 0; i < 6; i++) begin
         @(negedge clk_cam);
         h_ref    = 1'b1;
         cam_data = 8'(i + 1);
      end
      @(negedge clk_cam);
      h_ref   = 1'b0;
      reset_n = 1'b0;
      @(negedge clk_mem);
      check("midrow_reset_valid", 32'(command_data_valid), 32'd0);
      check("midrow_reset_cmd", 32'(command_data), 32'd0);
      check("midrow_reset_pixel", pixel_data, 32'd0);
      repeat (3) @(negedge clk_cam);
      reset_n = 1'b1;
      repeat (6) @(negedge clk_cam);

      pulse_vsync();
      repeat (40) @(negedge clk_mem);
      check("idle_no_cmd", 32'(got_q.size()), 32'd0);
      check("idle_no_valid", 32'(command_data_valid), 32'd0);

      init = 1'b1;
      pulse_vsync();
      expect_cmd(2'd1, "post_reset_start");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
